// File: rtl/small_divider.sv
// small_divider
//   Iterative restoring divider: 19-bit signed dividend / 8-bit signed divisor
//   giving an 11-bit signed quotient (saturated) and an 8-bit signed remainder.
//   Operates on magnitudes, one quotient bit per clock, and applies signs at the end.
//   Results truncate toward zero, and the remainder takes the sign of the dividend.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   in_valid     operands valid            in_ready    idle, operands accepted
//   dividend     signed [18:0]             divisor     signed [7:0]
//   out_valid    result valid (held)       out_ready   consumer takes result
//   quotient     signed [10:0]             remainder   signed [7:0]
//   overflow     quotient saturated        div_by_zero divisor was zero
//
// Optional build macro
//   SMALL_DIVIDER_ROUND_EN  round quotient to nearest (ties away from zero)
module small_divider (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [18:0] dividend,
  input  logic signed [7:0]  divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [10:0] quotient,
  output logic signed [7:0]  remainder,
  output logic               overflow,
  output logic               div_by_zero
);

  typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP, DONE} state_t;

  state_t             r_state;
  logic [4:0]         r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic signed [10:0] r_quo;
  logic signed [7:0]  r_rem;
  logic               r_ovf;
  logic               r_dbz;

  // r_shift starts as |dividend| and ends as |quotient|: dividend bits leave
  // at the MSB while quotient bits enter at the LSB.
  logic [18:0]        r_shift;
  logic [7:0]         r_prem;
  logic [7:0]         r_dsr_mag;
  logic               r_dvd_neg;
  logic               r_dsr_neg;

  logic               w_accept;
  logic [8:0]         w_trial;
  logic               w_ge;
  logic [7:0]         w_diff;
  logic [18:0]        w_qmag;
  logic [7:0]         w_rmag;
  logic               w_rneg;
  logic [11:0]        w_sat;

  // Two's-complement magnitudes. The unsigned result is exact even for the most
  // negative input: -262144 -> 0x40000 and -128 -> 0x80.
  function automatic logic [18:0] mag19(input logic [18:0] v);
    return v[18] ? (~v + 19'd1) : v;
  endfunction

  function automatic logic [7:0] mag8(input logic [7:0] v);
    return v[7] ? (~v + 8'd1) : v;
  endfunction

  // Returns {overflow, signed quotient}. A zero magnitude yields zero for either sign.
  function automatic logic [11:0] sat_quo(input logic [18:0] mag, input logic neg);
    logic [10:0] lo;
    lo = mag[10:0];
    if (neg) begin
      if (mag > 19'd1024) return {1'b1, 11'h400};
      else                return {1'b0, ~lo + 11'd1};
    end else begin
      if (mag > 19'd1023) return {1'b1, 11'h3FF};
      else                return {1'b0, lo};
    end
  endfunction

  function automatic logic [7:0] apply_sign8(input logic [7:0] mag, input logic neg);
    return neg ? (~mag + 8'd1) : mag;
  endfunction

  assign w_accept = in_valid & r_in_ready;

  // The partial remainder stays below |divisor| <= 128, so the difference fits in 8 bits.
  assign w_trial = {r_prem, r_shift[18]};
  assign w_ge    = w_trial >= {1'b0, r_dsr_mag};
  assign w_diff  = w_trial[7:0] - r_dsr_mag;

  always_comb begin
    w_qmag = r_shift;
    w_rmag = r_prem;
    w_rneg = r_dvd_neg;
`ifdef SMALL_DIVIDER_ROUND_EN
    // Rounding up the magnitude moves the remainder to the opposite side:
    // r' = r - sign*|d|, so its magnitude becomes |d| - |r| and its sign flips.
    if ({r_prem, 1'b0} >= {1'b0, r_dsr_mag}) begin
      w_qmag = r_shift + 19'd1;
      w_rmag = r_dsr_mag - r_prem;
      w_rneg = ~r_dvd_neg;
    end
`endif
  end

  assign w_sat = sat_quo(w_qmag, r_dvd_neg ^ r_dsr_neg);

  // Datapath: operand capture on accept, one restoring step per DIVIDE cycle
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shift   <= mag19(dividend);
      r_dsr_mag <= mag8(divisor);
      r_dvd_neg <= dividend[18];
      r_dsr_neg <= divisor[7];
      r_prem    <= 8'd0;
    end else if (r_state == DIVIDE) begin
      r_prem  <= w_ge ? w_diff : w_trial[7:0];
      r_shift <= {r_shift[17:0], w_ge};
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 5'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_ovf       <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            r_ovf      <= 1'b0;
            r_dbz      <= 1'b0;
            r_cnt      <= 5'd0;
            if (divisor == 8'sd0) begin
              r_quo       <= dividend[18] ? 11'sh400 : 11'sh3FF;
              r_rem       <= '0;
              r_dbz       <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_state <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd18) r_state <= FIXUP;
        end
        FIXUP: begin
          r_quo       <= w_sat[10:0];
          r_ovf       <= w_sat[11];
          r_rem       <= apply_sign8(w_rmag, w_rneg);
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign quotient    = r_quo;
  assign remainder   = r_rem;
  assign overflow    = r_ovf;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_small_divider.sv
module tb_small_divider;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [18:0] dividend;
  logic signed [7:0]  divisor;
  logic               out_valid;
  logic               out_ready;
  logic signed [10:0] quotient;
  logic signed [7:0]  remainder;
  logic               overflow;
  logic               div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  small_divider dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer division (truncates toward zero, remainder has the
  // dividend's sign), optional round-to-nearest, then clamp to 11 bits.
  task automatic model(input int a, input int d, output int q, output int r,
                       output int ovf, output int dbz);
    ovf = 0;
    dbz = 0;
    if (d == 0) begin
      q   = (a >= 0) ? 1023 : -1024;
      r   = 0;
      dbz = 1;
    end else begin
      q = a / d;
      r = a % d;
`ifdef SMALL_DIVIDER_ROUND_EN
      if (2 * ((r < 0) ? -r : r) >= ((d < 0) ? -d : d)) begin
        q = ((a < 0) != (d < 0)) ? q - 1 : q + 1;
        r = a - q * d;
      end
`endif
      if (q > 1023) begin
        q = 1023;
        ovf = 1;
      end else if (q < -1024) begin
        q = -1024;
        ovf = 1;
      end
    end
  endtask

  // Starts and ends at posedge+1 with the DUT idle.
  task automatic run_div(input int a, input int d, input int hold);
    int n;
    int eq, er, eo, ez;
    logic busy_ok, stable;
    logic signed [10:0] q0;
    logic signed [7:0]  r0;
    logic o0, z0;
    check("idle_in_ready", in_ready, 1);
    dividend = a[18:0];
    divisor  = d[7:0];
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    busy_ok = 1'b1;
    while (!out_valid && n < 30) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    if (in_ready) busy_ok = 1'b0;
    check($sformatf("latency %0d/%0d", a, d), n, (d == 0) ? 1 : 21);
    check("busy_in_ready_low", busy_ok, 1);
    model(a, d, eq, er, eo, ez);
    check($sformatf("quotient %0d/%0d", a, d), quotient, eq);
    check($sformatf("remainder %0d/%0d", a, d), remainder, er);
    check($sformatf("overflow %0d/%0d", a, d), overflow, eo);
    check($sformatf("div_by_zero %0d/%0d", a, d), div_by_zero, ez);
    if (hold > 0) begin
      q0 = quotient; r0 = remainder; o0 = overflow; z0 = div_by_zero;
      stable = 1'b1;
      repeat (hold) begin
        dividend = 19'($urandom);
        divisor  = 8'($urandom_range(1, 127));
        in_valid = 1'b1;
        @(posedge clk); #1;
        if (quotient !== q0 || remainder !== r0 || overflow !== o0 ||
            div_by_zero !== z0 || out_valid !== 1'b1 || in_ready !== 1'b0)
          stable = 1'b0;
      end
      in_valid = 1'b0;
      check("hold_stable", stable, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
  endtask

  initial begin
    int a, d;
    logic quiet;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_overflow", overflow, 0);
    check("rst_div_by_zero", div_by_zero, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_div(1000, 7, 0);
    run_div(-1000, 7, 0);
    run_div(1000, -7, 0);
    run_div(-1000, -7, 0);
    run_div(3, 7, 0);
    run_div(131072, -128, 0);
    run_div(131072, 1, 0);
    run_div(-262144, -1, 0);
    run_div(-5, 0, 0);
    run_div(5, 0, 0);
    run_div(10, 4, 0);
    run_div(-10, 4, 0);
    run_div(-4, -7, 0);
    run_div(262143, 127, 0);
    run_div(-262144, -128, 0);
    run_div(1000, 7, 5);

    // Abort mid-division: no result may appear afterwards.
    dividend = 19'sd1000;
    divisor  = 8'sd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    quiet = 1'b1;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) quiet = 1'b0;
    end
    check("abort_no_result", quiet, 1);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 1) == 1) a = int'($urandom_range(0, 524287)) - 262144;
      else                           a = int'($urandom_range(0, 60000)) - 30000;
      if ($urandom_range(0, 15) == 0) d = 0;
      else                            d = int'($urandom_range(0, 255)) - 128;
      run_div(a, d, int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
